cmd_cfg_param: RTL and testbench

Parametrised next-generation command configuration unit for the quadcopter flight controller. It sits between UART_wrapper (cmd/data/cmd_rdy in, resp/snd_resp out) and the flight/ADC/calibration logic. It decodes host commands into attitude and thrust setpoints, and sequences battery reads and inertial calibration. New in this generation: configurable setpoint widths, NAK for unknown opcodes, and a comm-loss watchdog that forces an emergency land.

---
 rtl/cmd_cfg_pkg.sv | 35 +++
 rtl/cmd_cfg_param_if.sv | 19 +
 rtl/cmd_wdog.sv | 30 +++
 rtl/cmd_cfg_param.sv | 159 +++++++++++++++
 tb/tb_cmd_cfg_param.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_cfg_pkg.sv
// Shared opcode, response and FSM state definitions for the command config unit.
package cmd_cfg_pkg;

  typedef enum logic [7:0] {
    OpReqBatt   = 8'h01,
    OpSetPtch   = 8'h02,
    OpSetRoll   = 8'h03,
    OpSetYaw    = 8'h04,
    OpSetThrst  = 8'h05,
    OpCalibrate = 8'h06,
    OpEmerLand  = 8'h07,
    OpMtrsOff   = 8'h08
  } opcode_e;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  typedef enum logic [1:0] {
    StIdle,
    StBattWait,
    StCalSpin,
    StCalWait
  } state_e;

  // Opcode is one of the eight defined commands.
  function automatic logic op_known(logic [7:0] op);
    return (op >= 8'h01) && (op <= 8'h08);
  endfunction

  // Opcodes whose response comes at the end of a multi-cycle sequence.
  function automatic logic op_deferred(logic [7:0] op);
    return (op == OpReqBatt) || (op == OpCalibrate);
  endfunction

endpackage

// File: rtl/cmd_cfg_param_if.sv
// Command/response handshake between the UART wrapper and the config unit.
interface cmd_cfg_param_if;
  logic       cmd_rdy;
  logic [7:0] cmd;
  logic [15:0] data;
  logic       clr_cmd_rdy;
  logic [7:0] resp;
  logic       send_resp;

  modport master (
    output cmd_rdy, cmd, data,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport slave (
    input  cmd_rdy, cmd, data,
    output clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/cmd_wdog.sv
// Comm-loss watchdog: saturating idle counter, cleared by kick.
module cmd_wdog #(
  parameter int unsigned WD_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic expired
);

  localparam logic [WD_W-1:0] CntMax     = '1;
  localparam logic [WD_W-1:0] CntNearMax = CntMax - WD_W'(1);

  logic [WD_W-1:0] cnt_q;

  // Count idle cycles, holding at the maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (kick) begin
      cnt_q <= '0;
    end else if (cnt_q != CntMax) begin
      cnt_q <= cnt_q + WD_W'(1);
    end
  end

  // High on the edge where the count reaches max and every cycle it stays there.
  assign expired = !kick && ((cnt_q == CntNearMax) || (cnt_q == CntMax));

endmodule

// File: rtl/cmd_cfg_param.sv
// Command configuration unit: decodes host commands into setpoints and
// sequences battery reads, inertial calibration and comm-loss landing.
module cmd_cfg_param #(
  parameter int unsigned D_W    = 16,
  parameter int unsigned THR_W  = 9,
  parameter int unsigned SPIN_W = 9,
  parameter int unsigned WD_W   = 20
) (
  input  logic             clk,
  input  logic             rst,
  cmd_cfg_param_if.slave   uart,
  input  logic [7:0]       batt,
  output logic             strt_cnv,
  input  logic             cnv_cmplt,
  output logic             inertial_cal,
  output logic             strt_cal,
  input  logic             cal_done,
  output logic             motors_off,
  output logic [D_W-1:0]   d_ptch,
  output logic [D_W-1:0]   d_roll,
  output logic [D_W-1:0]   d_yaw,
  output logic [THR_W-1:0] thrst,
  output logic             comm_lost
);
  import cmd_cfg_pkg::*;

  state_e            state_q, state_d;
  logic              accept;
  logic              clr_c;
  logic [SPIN_W-1:0] spin_q;
  logic              spin_done;
  logic              wd_expired;
  logic [7:0]        resp_q;
  logic              send_q;
  logic [D_W-1:0]    ptch_q, roll_q, yaw_q;
  logic [THR_W-1:0]  thr_q;
  logic              moff_q, ical_q, lost_q;

  assign accept    = (state_q == StIdle) && uart.cmd_rdy;
  assign spin_done = &spin_q;

  cmd_wdog #(
    .WD_W (WD_W)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .kick    (accept),
    .expired (wd_expired)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (uart.cmd_rdy && (uart.cmd == OpReqBatt))   state_d = StBattWait;
        if (uart.cmd_rdy && (uart.cmd == OpCalibrate)) state_d = StCalSpin;
      end
      StBattWait: if (cnv_cmplt) state_d = StIdle;
      StCalSpin:  if (spin_done) state_d = StCalWait;
      StCalWait:  if (cal_done)  state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // FSM combinational strobes.
  always_comb begin
    clr_c    = accept;
    strt_cnv = accept && (uart.cmd == OpReqBatt);
    strt_cal = (state_q == StCalSpin) && spin_done;
  end

  // Motor spin-up counter; held at zero outside CAL_SPIN so it starts clean.
  always_ff @(posedge clk) begin
    if (rst)                       spin_q <= '0;
    else if (state_q == StCalSpin) spin_q <= spin_q + SPIN_W'(1);
    else                           spin_q <= '0;
  end

  // Response byte and one-cycle send pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= '0;
      send_q <= 1'b0;
    end else begin
      send_q <= 1'b0;
      if (accept && !op_deferred(uart.cmd)) begin
        resp_q <= op_known(uart.cmd) ? ACK : NAK;
        send_q <= 1'b1;
      end else if ((state_q == StBattWait) && cnv_cmplt) begin
        resp_q <= batt;
        send_q <= 1'b1;
      end else if ((state_q == StCalWait) && cal_done) begin
        resp_q <= ACK;
        send_q <= 1'b1;
      end
    end
  end

  // Setpoints, motor/calibration flags and comm-loss; an accepted command beats expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptch_q <= '0;
      roll_q <= '0;
      yaw_q  <= '0;
      thr_q  <= '0;
      moff_q <= 1'b1;
      ical_q <= 1'b0;
      lost_q <= 1'b0;
    end else if (accept) begin
      lost_q <= 1'b0;
      case (uart.cmd)
        OpSetPtch:  ptch_q <= uart.data[D_W-1:0];
        OpSetRoll:  roll_q <= uart.data[D_W-1:0];
        OpSetYaw:   yaw_q  <= uart.data[D_W-1:0];
        OpSetThrst: thr_q  <= uart.data[THR_W-1:0];
        OpEmerLand: begin
          ptch_q <= '0;
          roll_q <= '0;
          yaw_q  <= '0;
          thr_q  <= '0;
        end
        OpMtrsOff:  moff_q <= 1'b1;
        OpCalibrate: begin
          moff_q <= 1'b0;
          ical_q <= 1'b1;
        end
        default: ;
      endcase
    end else begin
      if (wd_expired) begin
        lost_q <= 1'b1;
        ptch_q <= '0;
        roll_q <= '0;
        yaw_q  <= '0;
        thr_q  <= '0;
      end
      if ((state_q == StCalWait) && cal_done) ical_q <= 1'b0;
    end
  end

  assign uart.clr_cmd_rdy = clr_c;
  assign uart.resp        = resp_q;
  assign uart.send_resp   = send_q;
  assign d_ptch           = ptch_q;
  assign d_roll           = roll_q;
  assign d_yaw            = yaw_q;
  assign thrst            = thr_q;
  assign motors_off       = moff_q;
  assign inertial_cal     = ical_q;
  assign comm_lost        = lost_q;

endmodule

// File: tb/tb_cmd_cfg_param.sv
// Randomized bench for cmd_cfg_param with a transaction-level reference model.
module tb_cmd_cfg_param;
  import cmd_cfg_pkg::*;

  localparam int unsigned D_W      = 10;
  localparam int unsigned THR_W    = 9;
  localparam int unsigned SPIN_W   = 4;
  localparam int unsigned WD_W     = 6;
  localparam int          WD_MAX   = (1 << WD_W) - 1;
  localparam int          SPIN_CYC = 1 << SPIN_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       batt;
  logic             strt_cnv, cnv_cmplt, inertial_cal, strt_cal, cal_done;
  logic             motors_off, comm_lost;
  logic [D_W-1:0]   d_ptch, d_roll, d_yaw;
  logic [THR_W-1:0] thrst;

  cmd_cfg_param_if bus ();

  cmd_cfg_param #(
    .D_W    (D_W),
    .THR_W  (THR_W),
    .SPIN_W (SPIN_W),
    .WD_W   (WD_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart         (bus),
    .batt         (batt),
    .strt_cnv     (strt_cnv),
    .cnv_cmplt    (cnv_cmplt),
    .inertial_cal (inertial_cal),
    .strt_cal     (strt_cal),
    .cal_done     (cal_done),
    .motors_off   (motors_off),
    .d_ptch       (d_ptch),
    .d_roll       (d_roll),
    .d_yaw        (d_yaw),
    .thrst        (thrst),
    .comm_lost    (comm_lost)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [D_W-1:0]   m_ptch, m_roll, m_yaw;
  logic [THR_W-1:0] m_thr;
  logic             m_lost, m_moff, m_ical, m_send, m_send_pend;
  logic [7:0]       m_resp;
  int               wd;
  int               n_total = 0;
  int               n_bad   = 0;

  logic             pend_valid;
  logic [7:0]       pend_op;
  logic [15:0]      pend_dat;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs();
    check_eq("setpoints", 64'({d_ptch, d_roll, d_yaw, thrst}),
             64'({m_ptch, m_roll, m_yaw, m_thr}));
    check_eq("comm_lost", 64'(comm_lost), 64'(m_lost));
    check_eq("motors_off", 64'(motors_off), 64'(m_moff));
    check_eq("inertial_cal", 64'(inertial_cal), 64'(m_ical));
    check_eq("send_resp", 64'(bus.send_resp), 64'(m_send));
    check_eq("resp", 64'(bus.resp), 64'(m_resp));
  endtask

  task automatic chk_comb(input logic clr, input logic cnv, input logic cal);
    #1;
    check_eq("clr_cmd_rdy", 64'(bus.clr_cmd_rdy), 64'(clr));
    check_eq("strt_cnv", 64'(strt_cnv), 64'(cnv));
    check_eq("strt_cal", 64'(strt_cal), 64'(cal));
  endtask

  task automatic zero_model();
    m_ptch = '0;
    m_roll = '0;
    m_yaw  = '0;
    m_thr  = '0;
  endtask

  // One clock; the watchdog rule is applied to the model on the edge.
  task automatic step(input logic acc);
    @(posedge clk);
    if (acc) begin
      wd     = 0;
      m_lost = 1'b0;
    end else begin
      if (wd < WD_MAX) wd++;
      if (wd == WD_MAX) begin
        m_lost = 1'b1;
        zero_model();
      end
    end
    m_send      = m_send_pend;
    m_send_pend = 1'b0;
    @(negedge clk);
    check_regs();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.cmd_rdy = 1'b0;
    cnv_cmplt   = 1'b0;
    cal_done    = 1'b0;
    @(posedge clk);
    zero_model();
    m_moff      = 1'b1;
    m_ical      = 1'b0;
    m_lost      = 1'b0;
    m_resp      = 8'h00;
    m_send      = 1'b0;
    m_send_pend = 1'b0;
    wd          = 0;
    @(negedge clk);
    check_regs();
    chk_comb(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.cmd_rdy = 1'b0;
    repeat (n) step(1'b0);
  endtask

  // Any single-cycle command (everything except REQ_BATT and CALIBRATE).
  task automatic do_simple(input logic [7:0] op, input logic [15:0] dat);
    bus.cmd_rdy = 1'b1;
    bus.cmd     = op;
    bus.data    = dat;
    chk_comb(1'b1, 1'b0, 1'b0);
    case (op)
      OpSetPtch:  m_ptch = dat[D_W-1:0];
      OpSetRoll:  m_roll = dat[D_W-1:0];
      OpSetYaw:   m_yaw  = dat[D_W-1:0];
      OpSetThrst: m_thr  = dat[THR_W-1:0];
      OpEmerLand: zero_model();
      OpMtrsOff:  m_moff = 1'b1;
      default: ;
    endcase
    m_resp      = (op >= 8'h02 && op <= 8'h08) ? ACK : NAK;
    m_send_pend = 1'b1;
    step(1'b1);
    bus.cmd_rdy = 1'b0;
  endtask

  task automatic hold_pending(input logic p, input logic [7:0] pop, input logic [15:0] pdat);
    bus.cmd_rdy = p;
    bus.cmd     = pop;
    bus.data    = pdat;
  endtask

  task automatic do_batt(input logic [7:0] b, input int w, input logic p,
                         input logic [7:0] pop, input logic [15:0] pdat);
    bus.cmd_rdy = 1'b1;
    bus.cmd     = OpReqBatt;
    bus.data    = 16'($urandom);
    chk_comb(1'b1, 1'b1, 1'b0);
    step(1'b1);
    hold_pending(p, pop, pdat);
    repeat (w) begin
      chk_comb(1'b0, 1'b0, 1'b0);
      step(1'b0);
    end
    batt      = b;
    cnv_cmplt = 1'b1;
    chk_comb(1'b0, 1'b0, 1'b0);
    m_resp      = b;
    m_send_pend = 1'b1;
    step(1'b0);
    cnv_cmplt = 1'b0;
    batt      = 8'($urandom);
  endtask

  task automatic do_cal(input int d, input logic p, input logic [7:0] pop,
                        input logic [15:0] pdat, input logic abort);
    bus.cmd_rdy = 1'b1;
    bus.cmd     = OpCalibrate;
    chk_comb(1'b1, 1'b0, 1'b0);
    m_moff = 1'b0;
    m_ical = 1'b1;
    step(1'b1);
    hold_pending(p, pop, pdat);
    for (int k = 1; k <= SPIN_CYC; k++) begin
      chk_comb(1'b0, 1'b0, k == SPIN_CYC);
      step(1'b0);
    end
    repeat (d) begin
      chk_comb(1'b0, 1'b0, 1'b0);
      step(1'b0);
    end
    if (abort) begin
      do_reset();
    end else begin
      cal_done = 1'b1;
      chk_comb(1'b0, 1'b0, 1'b0);
      m_ical      = 1'b0;
      m_resp      = ACK;
      m_send_pend = 1'b1;
      step(1'b0);
      cal_done = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] op;
    int         r;
    rst         = 1'b1;
    bus.cmd_rdy = 1'b0;
    bus.cmd     = 8'h00;
    bus.data    = 16'h0000;
    batt        = 8'h00;
    cnv_cmplt   = 1'b0;
    cal_done    = 1'b0;
    pend_valid  = 1'b0;
    do_reset();

    // Directed scenarios.
    do_simple(OpSetPtch, 16'h0006);
    check_eq("ptch_set", 64'(d_ptch), 64'd6);
    do_simple(OpSetRoll, 16'hFC04);
    check_eq("roll_trunc", 64'(d_roll), 64'h004);
    do_simple(8'h42, 16'($urandom));
    check_eq("nak_resp", 64'(bus.resp), 64'hEE);
    do_batt(8'h21, 9, 1'b0, 8'h00, 16'h0000);
    check_eq("batt_resp", 64'(bus.resp), 64'h21);
    do_simple(OpMtrsOff, 16'h0000);
    do_cal(4, 1'b1, OpSetYaw, 16'h0003, 1'b0);
    do_simple(OpSetYaw, 16'h0003);
    check_eq("pending_yaw", 64'(d_yaw), 64'd3);
    do_simple(OpSetThrst, 16'h0008);
    idle(62);
    check_eq("wd_not_yet", 64'(comm_lost), 64'd0);
    idle(1);
    check_eq("wd_expired", 64'(comm_lost), 64'd1);
    check_eq("wd_thrst", 64'(thrst), 64'd0);
    do_simple(OpSetYaw, 16'h0002);
    check_eq("wd_cleared", 64'(comm_lost), 64'd0);
    check_eq("wd_yaw", 64'(d_yaw), 64'd2);

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      if (pend_valid) begin
        pend_valid = 1'b0;
        do_simple(pend_op, pend_dat);
      end
      r = int'($urandom_range(0, 10));
      if (r <= 3) begin
        op = 8'(int'(OpSetPtch) + r);
        do_simple(op, 16'($urandom));
      end else if (r == 4) begin
        do_simple(OpEmerLand, 16'($urandom));
      end else if (r == 5) begin
        do_simple(OpMtrsOff, 16'($urandom));
      end else if (r == 6) begin
        op = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(9, 255));
        do_simple(op, 16'($urandom));
      end else if (r == 7 || r == 8) begin
        pend_valid = 1'($urandom_range(0, 1));
        pend_op    = 8'(int'(OpSetPtch) + int'($urandom_range(0, 3)));
        pend_dat   = 16'($urandom);
        if (r == 7) do_batt(8'($urandom), int'($urandom_range(0, 12)), pend_valid, pend_op,
                            pend_dat);
        else        do_cal(int'($urandom_range(0, 6)), pend_valid, pend_op, pend_dat, 1'b0);
      end else begin
        idle(int'($urandom_range(0, 80)));
      end
    end
    if (pend_valid) do_simple(pend_op, pend_dat);

    // Reset while waiting for cal_done.
    do_simple(OpSetPtch, 16'h0155);
    do_cal(2, 1'b0, 8'h00, 16'h0000, 1'b1);
    check_eq("abort_moff", 64'(motors_off), 64'd1);
    check_eq("abort_ical", 64'(inertial_cal), 64'd0);
    check_eq("abort_ptch", 64'(d_ptch), 64'd0);
    idle(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
